// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, memory address and the memory responder state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [19:0] lc3b_addr;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lc3b_mem_state;

endpackage

// File: rtl/tri_buff.sv
// Tristate buffer: drives d onto q while en is high, otherwise releases the net.
module tri_buff #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    inout  wire  [WIDTH-1:0] q
);

    assign q = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: turns a held read/write request into a timed
// asynchronous SRAM access and returns a single-cycle completion strobe.
module mem_responder
    import lc3b_types::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] mem_byte_en,
    input  lc3b_addr   mem_address,
    input  lc3b_word   mem_wdata,
    output lc3b_word   mem_rdata,
    output logic       mem_resp,
    output logic       busy,
    output logic       CE_N,
    output logic       OE_N,
    output logic       WE_N,
    output logic       UB_N,
    output logic       LB_N,
    output lc3b_addr   sram_addr,
    inout  wire [15:0] sram_data
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    lc3b_mem_state state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [1:0]    be_q;
    lc3b_word      wdata_q;
    logic          in_access;
    logic          drive_en;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_write  <= 1'b0;
            be_q      <= 2'b00;
            wdata_q   <= '0;
            sram_addr <= '0;
            mem_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A simultaneous read and write resolves to the write.
                    if (mem_read || mem_write) begin
                        state     <= ACCESS;
                        cnt       <= 4'd0;
                        op_write  <= mem_write;
                        be_q      <= mem_byte_en;
                        wdata_q   <= mem_wdata;
                        sram_addr <= mem_address;
                    end
                end
                ACCESS: begin
                    if (cnt < WAIT_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        state <= RESP;
                        if (!op_write) begin
                            mem_rdata <= sram_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM strobes decode straight from registered state so reset clears them at once.
    // WE_N rises one cycle before the access ends so write data holds past the strobe.
    assign in_access = (state == ACCESS);
    assign drive_en  = in_access && op_write;
    assign busy      = (state != IDLE);
    assign mem_resp  = (state == RESP);
    assign CE_N      = ~in_access;
    assign OE_N      = ~(in_access && !op_write);
    assign WE_N      = ~(drive_en && (cnt < WAIT_CNT));
    assign UB_N      = ~(in_access && (!op_write || be_q[1]));
    assign LB_N      = ~(in_access && (!op_write || be_q[0]));

    tri_buff #(
        .WIDTH(16)
    ) u_data_buf (
        .en(drive_en),
        .d (wdata_q),
        .q (sram_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a word-array model.
`timescale 1ns/1ps
module tb_mem_responder;
    import lc3b_types::*;

    localparam int W  = 2;
    localparam int W1 = 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_en;
    logic [19:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp, busy, CE_N, OE_N, WE_N, UB_N, LB_N;
    logic [19:0] sram_addr;
    wire  [15:0] sram_data;

    logic        rd1;
    logic [19:0] addr1;
    logic [15:0] rdata1;
    logic        resp1, busy1, ce1, oe1, we1, ub1, lb1;
    logic [19:0] saddr1;
    wire  [15:0] bus1;

    int checks = 0;
    int errors = 0;
    int we1_low = 0;

    logic [15:0] sram    [0:127] = '{default: 16'hBEEF};
    logic [15:0] ref_mem [0:127] = '{default: 16'hBEEF};
    logic [15:0] last_rd;

    always #5 Clk = ~Clk;

    mem_responder #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_en(mem_byte_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy),
        .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
        .sram_addr(sram_addr), .sram_data(sram_data)
    );

    mem_responder #(.WAIT_CYCLES(W1)) dut1 (
        .Clk(Clk), .Reset(Reset), .mem_read(rd1), .mem_write(1'b0),
        .mem_byte_en(2'b11), .mem_address(addr1), .mem_wdata(16'h0000),
        .mem_rdata(rdata1), .mem_resp(resp1), .busy(busy1),
        .CE_N(ce1), .OE_N(oe1), .WE_N(we1), .UB_N(ub1), .LB_N(lb1),
        .sram_addr(saddr1), .sram_data(bus1)
    );

    // Asynchronous SRAM device: drives the bus on output enable, latches bytes while WE_N is low.
    assign sram_data = (!CE_N && !OE_N) ? sram[sram_addr[6:0]] : 16'hzzzz;
    always @(posedge Clk) begin
        if (!CE_N && !WE_N) begin
            if (!UB_N) sram[sram_addr[6:0]][15:8] <= sram_data[15:8];
            if (!LB_N) sram[sram_addr[6:0]][7:0]  <= sram_data[7:0];
        end
    end

    assign bus1 = (!ce1 && !oe1) ? (saddr1[15:0] ^ 16'h5A5A) : 16'hzzzz;
    always @(posedge Clk) if (we1 === 1'b0) we1_low++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [19:0] a,
                             input logic [15:0] d, input logic [1:0] be, input string tag);
        int   oe_cnt  = 0;
        int   we_cnt  = 0;
        int   resp_at = -1;
        int   ctl_bad = 0;
        int   bus_bad = 0;
        logic [15:0] old;
        @(negedge Clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_en = be;
        @(posedge Clk);
        for (int j = 0; j <= 10 && resp_at < 0; j++) begin
            if (j > 0) @(posedge Clk);
            #1;
            if (j == 0 && busy !== 1'b1) ctl_bad++;
            if (mem_resp === 1'b1) begin
                resp_at = j;
                if ({CE_N, OE_N, WE_N, UB_N, LB_N} !== 5'b11111) ctl_bad++;
            end
            if (OE_N === 1'b0) oe_cnt++;
            if (WE_N === 1'b0) begin
                we_cnt++;
                if (sram_data !== d) bus_bad++;
            end
            if (CE_N === 1'b0) begin
                if (sram_addr !== a) ctl_bad++;
                if (wr && {UB_N, LB_N} !== ~be) ctl_bad++;
                if (!wr && {UB_N, LB_N} !== 2'b00) ctl_bad++;
            end
        end
        @(negedge Clk);
        mem_read = 1'b0; mem_write = 1'b0;
        check({tag, "_latency"}, resp_at, W + 1);
        check({tag, "_ctl"}, ctl_bad, 0);
        if (wr) begin
            old = ref_mem[a[6:0]];
            ref_mem[a[6:0]] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
            check({tag, "_we_cycles"}, we_cnt, W);
            check({tag, "_oe_cycles"}, oe_cnt, 0);
            check({tag, "_bus"}, bus_bad, 0);
            check({tag, "_sram"}, sram[a[6:0]], ref_mem[a[6:0]]);
            check({tag, "_rdata_hold"}, mem_rdata, last_rd);
        end else begin
            last_rd = ref_mem[a[6:0]];
            check({tag, "_oe_cycles"}, oe_cnt, W + 1);
            check({tag, "_we_cycles"}, we_cnt, 0);
            check({tag, "_rdata"}, mem_rdata, last_rd);
        end
        @(posedge Clk);
        #1;
        check({tag, "_resp_single"}, {mem_resp, busy}, 2'b00);
    endtask

    initial begin
        int n_resp;
        int r1;
        int r2;
        int resp_at;
        bit rd;
        bit wr;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_en = 2'b00;
        mem_address = '0; mem_wdata = '0; rd1 = 1'b0; addr1 = '0;
        last_rd = 16'h0000;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_ctl", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'b11111);
        check("reset_status", {mem_resp, busy}, 2'b00);
        check("reset_rdata", mem_rdata, 16'h0000);
        check("reset_addr", sram_addr, 20'h00000);
        @(negedge Clk);
        Reset = 1'b0;

        do_access(1'b1, 1'b0, 20'h00012, 16'h0000, 2'b00, "read_beef");
        check("read_beef_value", mem_rdata, 16'hBEEF);
        do_access(1'b0, 1'b1, 20'h00040, 16'h1234, 2'b01, "write_lo");
        check("write_lo_value", sram[7'h40], 16'hBE34);
        do_access(1'b1, 1'b1, 20'h00005, 16'hA5A5, 2'b11, "rw_both");
        do_access(1'b1, 1'b0, 20'h00005, 16'h0000, 2'b00, "rw_readback");
        check("rw_readback_value", mem_rdata, 16'hA5A5);

        // Request held through the response: the next access begins W+3 edges after the first.
        @(negedge Clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 20'h00012;
        @(posedge Clk);
        n_resp = 0; r1 = -1; r2 = -1;
        for (int j = 0; j <= 14; j++) begin
            if (j > 0) @(posedge Clk);
            #1;
            if (mem_resp === 1'b1) begin
                n_resp++;
                if (r1 < 0) r1 = j;
                else r2 = j;
            end
            if (r2 >= 0 && mem_read) begin
                @(negedge Clk);
                mem_read = 1'b0;
            end
        end
        mem_read = 1'b0;
        check("held_first_resp", r1, W + 1);
        check("held_second_resp", r2, (W + 3) + (W + 1));
        check("held_resp_count", n_resp, 2);
        check("held_rdata", mem_rdata, ref_mem[7'h12]);
        last_rd = ref_mem[7'h12];

        for (int t = 0; t < 24; t++) begin
            int op;
            op = int'($urandom_range(0, 2));
            rd = (op != 1);
            wr = (op != 0);
            do_access(rd, wr, 20'($urandom_range(0, 126)), 16'($urandom),
                      2'($urandom_range(0, 3)), "rand");
        end

        // Reset dropped into the second ACCESS cycle of a write.
        @(negedge Clk);
        mem_write = 1'b1; mem_read = 1'b0; mem_address = 20'h0007F;
        mem_wdata = 16'h0F0F; mem_byte_en = 2'b11;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        check("abort_pre_we", WE_N, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check("abort_ctl", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'b11111);
        check("abort_status", {mem_resp, busy}, 2'b00);
        check("abort_rdata", mem_rdata, 16'h0000);
        mem_write = 1'b0;
        last_rd = 16'h0000;
        @(negedge Clk);
        Reset = 1'b0;
        n_resp = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge Clk);
            #1;
            if (mem_resp === 1'b1) n_resp++;
        end
        check("abort_no_resp", n_resp, 0);
        do_access(1'b1, 1'b0, 20'h00005, 16'h0000, 2'b00, "post_reset_read");
        check("post_reset_value", mem_rdata, 16'hA5A5);

        // Single-wait-cycle instance.
        @(negedge Clk);
        rd1 = 1'b1; addr1 = 20'h00333;
        @(posedge Clk);
        resp_at = -1;
        for (int j = 0; j <= 8 && resp_at < 0; j++) begin
            if (j > 0) @(posedge Clk);
            #1;
            if (resp1 === 1'b1) resp_at = j;
        end
        @(negedge Clk);
        rd1 = 1'b0;
        check("w1_latency", resp_at, W1 + 1);
        check("w1_rdata", rdata1, 16'h0333 ^ 16'h5A5A);
        check("w1_we_never_low", we1_low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
